// File: rtl/im_bank_if.sv
// Fetch and program-load bus of the instruction-memory bank.
// The master drives fetch addresses and load beats; the slave is the bank.
interface im_bank_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] IMIn;
  logic              im_hold;
  logic [31:0]       IMOut;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              busy;
  logic [ADDR_W:0]   load_count;
  logic              wrap_err;
  logic              par_err;

  modport master (
    output IMIn, im_hold, load_start, load_base, load_valid, load_data, load_last,
    input  IMOut, load_ready, busy, load_count, wrap_err, par_err
  );

  modport slave (
    input  IMIn, im_hold, load_start, load_base, load_valid, load_data, load_last,
    output IMOut, load_ready, busy, load_count, wrap_err, par_err
  );
endinterface

// File: rtl/im_bank.sv
// Instruction-memory bank: registered 1-cycle fetch port plus a streaming program loader.
// Optional feature macro IM_PARITY_EN adds a per-word even-parity bit checked on every fetch.
module im_bank #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2**ADDR_W
) (
  input logic       clk,
  input logic       rst,
  im_bank_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrapErr_q, wrapErr_d;
  logic              parErr_q, parErr_d;
  logic [31:0]       imOut_q, imOut_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdWord;
  logic              parBad;
  logic              accept;
  logic              busyNow;

  assign busyNow = (state_q != IDLE);
  assign accept  = bus.load_valid && (state_q == LOAD);
  assign rdWord  = mem_q[bus.IMIn];

`ifdef IM_PARITY_EN
  logic par_q [DEPTH];

  // Stored bit makes data plus parity even; any odd total flags a corrupted word.
  assign parBad = (^rdWord) != par_q[bus.IMIn];

  always_ff @(posedge clk) begin
    if (accept) begin
      par_q[wptr_q] <= ^bus.load_data;
    end
  end
`else
  assign parBad = 1'b0;
`endif

  // Memory has no reset so a load survives a reset pulse.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= bus.load_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    wrapErr_d = wrapErr_q;
    parErr_d  = parErr_q;
    imOut_d   = imOut_q;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          wptr_d  = bus.load_base;
          count_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          wptr_d  = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if ((wptr_q == LAST_ADDR) && !bus.load_last) begin
            wrapErr_d = 1'b1;
          end
          if (bus.load_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bubbles while loading take priority over the fetch stall.
    if (busyNow) begin
      imOut_d = 32'd0;
    end else if (!bus.im_hold) begin
      if (parBad) begin
        imOut_d  = 32'd0;
        parErr_d = 1'b1;
      end else begin
        imOut_d = rdWord;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      count_q   <= '0;
      wrapErr_q <= 1'b0;
      parErr_q  <= 1'b0;
      imOut_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      wrapErr_q <= wrapErr_d;
      parErr_q  <= parErr_d;
      imOut_q   <= imOut_d;
    end
  end

  assign bus.IMOut      = imOut_q;
  assign bus.load_ready = (state_q == LOAD);
  assign bus.busy       = busyNow;
  assign bus.load_count = count_q;
  assign bus.wrap_err   = wrapErr_q;
  assign bus.par_err    = parErr_q;

endmodule

// File: tb/tb_im_bank.sv
// Self-checking bench for im_bank: directed load/fetch scenarios then randomized traffic
// compared every cycle against a behavioural model of the bank.
module tb_im_bank;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  im_bank_if #(.ADDR_W(AW)) bus();

  im_bank #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] refMem     [DEPTH];
  bit          refKnown   [DEPTH];
  bit          refCorrupt [DEPTH];
  bit          loading;
  bit          draining;
  int          wptr;
  int          count;
  bit          wrapE;
  bit          parE;
  logic [31:0] expOut;
  bit          expKnown;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic setIdle();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.im_hold    = 1'b0;
  endtask

  // Behavioural view: a load is a window of accepted beats followed by one drain cycle.
  task automatic modelStep();
    bit busyNow;
    int a;
    busyNow = loading || draining;
    if (busyNow) begin
      expOut   = 32'd0;
      expKnown = 1'b1;
    end else if (!bus.im_hold) begin
      a = int'(bus.IMIn);
      if (refCorrupt[a]) begin
        expOut   = 32'd0;
        expKnown = 1'b1;
        parE     = 1'b1;
      end else begin
        expOut   = refMem[a];
        expKnown = refKnown[a];
      end
    end
    if (loading && bus.load_valid) begin
      refMem[wptr]     = bus.load_data;
      refKnown[wptr]   = 1'b1;
      refCorrupt[wptr] = 1'b0;
      if (wptr == DEPTH - 1 && !bus.load_last) wrapE = 1'b1;
      wptr  = (wptr + 1) % DEPTH;
      count = count + 1;
      if (bus.load_last) begin
        loading  = 1'b0;
        draining = 1'b1;
      end
    end else if (draining) begin
      draining = 1'b0;
    end
    if (!busyNow && bus.load_start) begin
      loading = 1'b1;
      wptr    = int'(bus.load_base);
      count   = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("busy",       32'(bus.busy),       32'(loading || draining));
    checkOutput("load_ready", 32'(bus.load_ready), 32'(loading));
    checkOutput("load_count", 32'(bus.load_count), 32'(count));
    checkOutput("wrap_err",   32'(bus.wrap_err),   32'(wrapE));
    checkOutput("par_err",    32'(bus.par_err),    32'(parE));
    if (expKnown) checkOutput("IMOut", bus.IMOut, expOut);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  // Asserts reset away from the clock edge, checks the cleared state, then releases it.
  task automatic resetDut();
    rst = 1'b0;
    #1;
    loading  = 1'b0;
    draining = 1'b0;
    wptr     = 0;
    count    = 0;
    wrapE    = 1'b0;
    parE     = 1'b0;
    expOut   = 32'd0;
    expKnown = 1'b1;
    checkAll();
    checkOutput("rst_IMOut", bus.IMOut, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic startLoad(input logic [AW-1:0] base);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    applyStimulus();
    bus.load_start = 1'b0;
  endtask

  task automatic sendBeat(input logic [31:0] data, input bit last);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    applyStimulus();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i]     = 32'd0;
      refKnown[i]   = 1'b0;
      refCorrupt[i] = 1'b0;
    end
    bus.IMIn      = '0;
    bus.load_base = '0;
    bus.load_data = 32'd0;
    setIdle();
    rst = 1'b0;
    resetDut();

    // Three-word program at 0x010, then fetch 0x011.
    startLoad(8'h10);
    sendBeat(32'h00A00093, 1'b0);
    sendBeat(32'h00100113, 1'b0);
    sendBeat(32'h002081B3, 1'b1);
    checkOutput("req33_count", 32'(bus.load_count), 32'd3);
    checkOutput("req33_busy_drain", 32'(bus.busy), 32'd1);
    bus.IMIn = 8'h11;
    applyStimulus();
    checkOutput("req33_busy_fall", 32'(bus.busy), 32'd0);
    applyStimulus();
    checkOutput("req33_fetch", bus.IMOut, 32'h00100113);

    // Fetch stall holds the word while the address wanders.
    bus.IMIn = 8'h10;
    applyStimulus();
    bus.im_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IMIn = 8'(8'h11 + i);
      applyStimulus();
      checkOutput("req34_hold", bus.IMOut, 32'h00A00093);
    end
    bus.im_hold = 1'b0;

    // Gapped beats while a fetch is pending.
    bus.IMIn = 8'h12;
    startLoad(8'h40);
    sendBeat(32'h11111111, 1'b0);
    applyStimulus();
    checkOutput("req38_bubble", bus.IMOut, 32'd0);
    sendBeat(32'h22222222, 1'b1);
    checkOutput("req38_count", 32'(bus.load_count), 32'd2);
    applyStimulus();
    bus.IMIn = 8'h41;
    applyStimulus();
    checkOutput("req38_fetch", bus.IMOut, 32'h22222222);

    // Reset in the middle of a load keeps the word already written.
    startLoad(8'h20);
    sendBeat(32'hCAFEF00D, 1'b0);
    @(posedge clk);
    #2;
    resetDut();
    checkOutput("req36_busy", 32'(bus.busy), 32'd0);
    bus.IMIn = 8'h20;
    applyStimulus();
    checkOutput("req36_fetch", bus.IMOut, 32'hCAFEF00D);

    // Load crossing the top of memory.
    startLoad(8'(DEPTH - 1));
    sendBeat(32'hAAAA0001, 1'b0);
    sendBeat(32'hAAAA0002, 1'b1);
    checkOutput("req35_wrap", 32'(bus.wrap_err), 32'd1);
    checkOutput("req35_count", 32'(bus.load_count), 32'd2);
    bus.IMIn = 8'h00;
    applyStimulus();
    applyStimulus();
    checkOutput("req35_addr0", bus.IMOut, 32'hAAAA0002);
    resetDut();
    checkOutput("wrap_cleared", 32'(bus.wrap_err), 32'd0);

    // Fill the whole bank so random fetches always have a known expectation.
    startLoad(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      sendBeat($urandom, (i == DEPTH - 1));
    end
    applyStimulus();
    checkOutput("fill_no_wrap", 32'(bus.wrap_err), 32'd0);

`ifdef IM_PARITY_EN
    dut.mem_q[7][3] = ~dut.mem_q[7][3];
    refCorrupt[7] = 1'b1;
    bus.IMIn = 8'd7;
    applyStimulus();
    checkOutput("req37_out", bus.IMOut, 32'd0);
    checkOutput("req37_par", 32'(bus.par_err), 32'd1);
    bus.IMIn = 8'd8;
    applyStimulus();
    checkOutput("req37_sticky", 32'(bus.par_err), 32'd1);
`else
    applyStimulus();
    checkOutput("req37_par_off", 32'(bus.par_err), 32'd0);
`endif

    for (int c = 0; c < 800; c++) begin
      bus.load_start = ($urandom_range(0, 9) == 0);
      bus.load_base  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH - 4, DEPTH - 1))
                                                    : 8'($urandom_range(0, DEPTH - 1));
      bus.load_valid = ($urandom_range(0, 2) != 0);
      bus.load_last  = ($urandom_range(0, 5) == 0);
      bus.load_data  = $urandom;
      bus.im_hold    = ($urandom_range(0, 3) == 0);
      bus.IMIn       = 8'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 199) == 0) begin
        setIdle();
        resetDut();
      end else begin
        applyStimulus();
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
